// File: rtl/mem_client_pkg.sv
`default_nettype none
// ============================================================================
// mem_client_pkg : shared types and defaults for the burst memory client
// Rev 1.0
// ============================================================================
package mem_client_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 5;
  localparam int MAX_BURST  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    XFER    = 3'd2,
    DRAIN   = 3'd3,
    RELEASE = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_burst_client.sv
`default_nettype none
// ============================================================================
// mem_burst_client : arbiter-facing burst master with read streaming and checksum
// Rev 1.0
// ============================================================================
module mem_burst_client
  import mem_client_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic              request,
  input  logic              granted,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_to_mem,
  output logic              read_write,
  input  logic [DATA_W-1:0] data_from_mem,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              write_q, write_d;
  logic              request_q, request_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_issued_q, rd_issued_d;

  logic              in_xfer;
  logic              op_now;
  logic [DATA_W-1:0] cur_word;

  assign in_xfer  = (state_q == XFER);
  assign op_now   = in_xfer & granted;
  assign cur_word = seed_q + DATA_W'(idx_q);

  // Bus is only driven in XFER; a grant anywhere else sees a read of address 0.
  assign addr        = in_xfer ? (base_q + ADDR_W'(idx_q)) : '0;
  assign read_write  = op_now & write_q;
  assign data_to_mem = (in_xfer & write_q) ? cur_word : '0;

  // Memory returns data one cycle after the address, so the word is passed
  // straight through in the cycle it arrives and held afterwards.
  assign rd_valid = rd_issued_q;
  assign rd_data  = rd_issued_q ? data_from_mem : rd_data_q;
  assign checksum = checksum_q;
  assign request  = request_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    seed_d      = seed_q;
    write_d     = write_q;
    request_d   = request_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_issued_d = 1'b0;
    rd_data_d   = rd_data_q;
    checksum_d  = checksum_q;

    if (rd_issued_q) begin
      rd_data_d  = data_from_mem;
      checksum_d = checksum_q + data_from_mem;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            base_d     = cmd_addr;
            len_d      = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
            seed_d     = cmd_data;
            write_d    = cmd_write;
            idx_d      = '0;
            checksum_d = '0;
            busy_d     = 1'b1;
            request_d  = 1'b1;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (granted) state_d = XFER;
      end
      XFER: begin
        if (granted) begin
          idx_d = idx_q + LEN_W'(1);
          if (write_q) checksum_d = checksum_q + cur_word;
          else         rd_issued_d = 1'b1;
          if (idx_q == len_q - LEN_W'(1)) begin
            if (write_q) begin
              request_d = 1'b0;
              state_d   = RELEASE;
            end else begin
              state_d   = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        request_d = 1'b0;
        state_d   = RELEASE;
      end
      RELEASE: begin
        if (!granted) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      seed_q      <= '0;
      write_q     <= 1'b0;
      request_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_issued_q <= 1'b0;
      rd_data_q   <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      write_q     <= write_d;
      request_q   <= request_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_issued_q <= rd_issued_d;
      rd_data_q   <= rd_data_d;
      checksum_q  <= checksum_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_client.sv
`default_nettype none
// ============================================================================
// tb_mem_burst_client : scoreboard bench with 1-cycle-latency memory and grant model
// Rev 1.0
// ============================================================================
module tb_mem_burst_client;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          granted = 1'b0;
  logic [DW-1:0] data_from_mem;
  logic          busy, done, request, read_write, rd_valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_to_mem, rd_data, checksum;

  mem_burst_client dut (
    .clk(clk), .rst(rst), .start(start), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .busy(busy), .done(done), .request(request), .granted(granted),
    .addr(addr), .data_to_mem(data_to_mem), .read_write(read_write),
    .data_from_mem(data_from_mem), .rd_valid(rd_valid), .rd_data(rd_data),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory behind the arbiter: registered read, one cycle latency
  logic [DW-1:0] mem [256];
  logic          mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      data_from_mem <= '0;
    end else begin
      if (read_write) mem[addr] <= data_to_mem;
      data_from_mem <= mem[addr];
    end
  end

  logic [DW-1:0] shadow [256];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t           wq [$];
  logic [DW-1:0] rq [$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  int done_cnt = 0;
  int last_rdv = -1;

  always @(negedge clk) begin
    if (!rst) begin
      if (read_write) begin
        chk("rw_needs_grant", 64'(granted), 64'd1);
        if (wq.size() == 0) chk("wr_extra", 64'(wq.size()), 64'd1);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", 64'(addr), 64'(e.a));
          chk("wr_data", 64'(data_to_mem), 64'(e.d));
        end
      end
      if (rd_valid) begin
        last_rdv = cyc;
        if (rq.size() == 0) chk("rd_extra", 64'(rq.size()), 64'd1);
        else chk("rd_data", 64'(rd_data), 64'(rq.pop_front()));
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] len,
                           input logic [DW-1:0] seed, input int gdly, input int stall_at,
                           input int stall_n, input bit poke);
    int            n, g, nwait, d0, rfall;
    logic [DW-1:0] sum;
    logic [AW-1:0] ai;
    wr_t           e;
    n   = (len > 5'd16) ? 16 : int'(len);
    sum = '0;
    for (int i = 0; i < n; i++) begin
      ai = a + AW'(i);
      if (wr) begin
        e.a = ai;
        e.d = seed + DW'(i);
        wq.push_back(e);
        shadow[ai] = e.d;
        sum += e.d;
      end else begin
        rq.push_back(shadow[ai]);
        sum += shadow[ai];
      end
    end
    d0 = done_cnt;
    start = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_data = seed;
    tick();
    start = 1'b0;
    chk("req_rise", 64'(request), 64'd1);
    chk("busy_rise", 64'(busy), 64'd1);
    if (poke) begin
      start = 1'b1; cmd_write = ~wr; cmd_addr = 8'hEE; cmd_len = 5'd3;
      tick();
      start = 1'b0;
    end
    repeat (gdly) tick();
    granted = 1'b1;
    g = cyc;
    tick();
    if (stall_n > 0) begin
      repeat (stall_at) tick();
      granted = 1'b0;
      for (int s = 0; s < stall_n; s++) begin
        #1;
        chk("stall_rw", 64'(read_write), 64'd0);
        chk("stall_addr", 64'(addr), 64'(a + AW'(stall_at)));
        tick();
      end
      granted = 1'b1;
    end
    nwait = 0;
    while (request && nwait < 60) begin
      tick();
      nwait++;
    end
    rfall = cyc;
    chk("req_fall", 64'(request), 64'd0);
    chk("req_fall_cyc", 64'(rfall), 64'(g + n + stall_n + (wr ? 1 : 2)));
    if (!wr) chk("rdv_last_cyc", 64'(last_rdv), 64'(rfall - 1));
    tick();
    granted = 1'b0;
    tick();
    chk("done", 64'(done), 64'd1);
    chk("checksum", 64'(checksum), 64'(sum));
    chk("busy_clr", 64'(busy), 64'd0);
    tick();
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("wq_empty", 64'(wq.size()), 64'd0);
    chk("rq_empty", 64'(rq.size()), 64'd0);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    repeat (3) tick();
    chk("rst_request", 64'(request), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bus", 64'({addr, read_write, data_to_mem}), 64'd0);
    chk("rst_rd", 64'({rd_valid, rd_data}), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    rst = 1'b0;
    mem_clr = 1'b0;
    tick();

    run_burst(1'b1, 8'h10, 5'd4, 32'h100, 2, 0, 0, 1'b1);
    chk("sum_10_13", 64'(checksum), 64'h406);
    run_burst(1'b0, 8'h10, 5'd4, 32'h0, 1, 0, 0, 1'b0);
    chk("rd_sum_10_13", 64'(checksum), 64'h406);
    run_burst(1'b1, 8'hFE, 5'd3, 32'h5000, 0, 0, 0, 1'b0);
    run_burst(1'b1, 8'h40, 5'd5, 32'hA0, 1, 2, 2, 1'b0);
    run_burst(1'b0, 8'h40, 5'd5, 32'h0, 3, 1, 1, 1'b0);
    run_burst(1'b1, 8'h80, 5'd20, 32'h0, 1, 0, 0, 1'b0);
    chk("clamp_sum", 64'(checksum), 64'd120);

    // Zero-length command completes without touching the bus
    start = 1'b1; cmd_write = 1'b1; cmd_len = 5'd0;
    tick();
    start = 1'b0;
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_req", 64'(request), 64'd0);
    chk("len0_busy", 64'(busy), 64'd0);
    tick();
    chk("len0_done_clr", 64'(done), 64'd0);
    chk("len0_req_after", 64'(request), 64'd0);

    // Reset in the middle of a read burst
    for (int i = 0; i < 8; i++) rq.push_back(shadow[8'h10 + i]);
    start = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_len = 5'd8;
    tick();
    start = 1'b0;
    granted = 1'b1;
    repeat (4) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_request", 64'(request), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_bus", 64'({addr, read_write}), 64'd0);
    chk("arst_rd", 64'({rd_valid, rd_data}), 64'd0);
    chk("arst_checksum", 64'(checksum), 64'd0);
    d0 = done_cnt;
    granted = 1'b0;
    rq.delete();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
    run_burst(1'b0, 8'hFE, 5'd3, 32'h0, 1, 0, 0, 1'b0);
    chk("post_rst_sum", 64'(checksum), 64'hF003);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
